// File: rtl/aes_state_assembler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : aes_asm_pkg                                               |
// | Purpose  : Shared constants, FSM encoding and slot-position helper   |
// |            for the AES column-word to state assembler.               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package aes_asm_pkg;

    localparam int AES_WORD_W    = 32;
    localparam int AES_NUM_WORDS = 4;
    localparam int AES_STATE_W   = AES_WORD_W * AES_NUM_WORDS;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } asm_state_t;

    // LSB position of column slot idx; column 0 occupies the top word.
    // With the default widths this is 96 - 32*idx.
    function automatic int slot_lsb(input int idx,
                                    input int word_w    = AES_WORD_W,
                                    input int num_words = AES_NUM_WORDS);
        return (num_words - 1 - idx) * word_w;
    endfunction

endpackage : aes_asm_pkg
`default_nettype wire

// File: rtl/aes_state_slot_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : aes_state_slot_reg                                        |
// | Purpose  : State-wide register built from independently enabled     |
// |            word slots sharing one word-wide write port.              |
// | Ports    : Clk      - rising-edge clock                              |
// |            Reset_n  - asynchronous active-low reset (clears slots)   |
// |            word_en  - one write enable per slot, slot 0 = column 0   |
// |            wr_word  - data written into every enabled slot           |
// |            q        - register contents, column 0 in the MSBs        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module aes_state_slot_reg
    import aes_asm_pkg::*;
#(
    parameter int WORD_W    = AES_WORD_W,
    parameter int NUM_WORDS = AES_NUM_WORDS
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic [NUM_WORDS-1:0]        word_en,
    input  logic [WORD_W-1:0]           wr_word,
    output logic [WORD_W*NUM_WORDS-1:0] q
);

    // Each slot is its own register so that every bit of q has a single
    // driver.
    generate
        for (genvar k = 0; k < NUM_WORDS; k++) begin : g_slot
            localparam int LSB = slot_lsb(k, WORD_W, NUM_WORDS);
            logic [WORD_W-1:0] r_word;

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    r_word <= '0;
                end else if (word_en[k]) begin
                    r_word <= wr_word;
                end
            end

            assign q[LSB +: WORD_W] = r_word;
        end
    endgenerate

endmodule : aes_state_slot_reg
`default_nettype wire

// File: rtl/aes_state_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : aes_state_assembler                                       |
// | Purpose  : Collects serial 32-bit column words into a 128-bit AES    |
// |            state and offers it downstream with valid/ready.          |
// | Ports    : Clk, Reset_n (async active-low)                           |
// |            clear      - synchronous abort of partial/pending state   |
// |            in_valid / in_ready / in_word   - column word input       |
// |            out_valid / out_ready / out_state - assembled state       |
// |            word_count - words held in the current partial state      |
// | Option   : AES_ASM_SKID_EN - adds a separate output register so the  |
// |            next state can fill while the previous one is pending.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module aes_state_assembler
    import aes_asm_pkg::*;
#(
    parameter int WORD_W    = AES_WORD_W,
    parameter int NUM_WORDS = AES_NUM_WORDS
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W-1:0]           in_word,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W*NUM_WORDS-1:0] out_state,
    output logic [1:0]                  word_count
);

    localparam int                STATE_W  = WORD_W * NUM_WORDS;
    localparam int                CNT_W    = 2;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_WORDS - 1);

    asm_state_t             r_state;
    asm_state_t             w_state_next;
    logic [CNT_W-1:0]       r_word_count;
    logic [CNT_W-1:0]       w_word_count_next;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   w_out_valid_next;
    logic                   w_in_xfer;
    logic                   w_out_xfer;
    logic [NUM_WORDS-1:0]   w_word_en;
    logic [STATE_W-1:0]     w_asm_q;
`ifdef AES_ASM_SKID_EN
    logic [STATE_W-1:0]     r_out_state;
    logic [STATE_W-1:0]     w_out_data;
    logic                   w_out_load;
`endif

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    // clear suppresses the slot write so an aborted word never lands.
    generate
        for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word_en
            assign w_word_en[k] = w_in_xfer && !clear && (r_word_count == CNT_W'(k));
        end
    endgenerate

    aes_state_slot_reg #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS)
    ) u_asm_reg (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .word_en (w_word_en),
        .wr_word (in_word),
        .q       (w_asm_q)
    );

    always_comb begin
        w_state_next      = r_state;
        w_word_count_next = r_word_count;
        w_out_valid_next  = r_out_valid;
`ifdef AES_ASM_SKID_EN
        w_out_load        = 1'b0;
        w_out_data        = w_asm_q;
`endif
        if (clear) begin
            w_state_next      = FILL;
            w_word_count_next = '0;
            w_out_valid_next  = 1'b0;
        end else begin
            case (r_state)
                FILL: begin
`ifdef AES_ASM_SKID_EN
                    if (w_out_xfer) begin
                        w_out_valid_next = 1'b0;
                    end
`endif
                    if (w_in_xfer) begin
                        if (r_word_count == LAST_IDX) begin
                            w_word_count_next = '0;
`ifdef AES_ASM_SKID_EN
                            // Hand the completed state (last word taken
                            // straight from the input) to the output
                            // register if it is free or draining now.
                            if (!r_out_valid || out_ready) begin
                                w_out_load       = 1'b1;
                                w_out_data       = {w_asm_q[STATE_W-1:WORD_W], in_word};
                                w_out_valid_next = 1'b1;
                            end else begin
                                w_state_next = FULL;
                            end
`else
                            w_state_next     = FULL;
                            w_out_valid_next = 1'b1;
`endif
                        end else begin
                            w_word_count_next = r_word_count + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (w_out_xfer) begin
                        w_state_next = FILL;
`ifdef AES_ASM_SKID_EN
                        // Held state replaces the one being drained.
                        w_out_load       = 1'b1;
                        w_out_valid_next = 1'b1;
`else
                        w_out_valid_next = 1'b0;
`endif
                    end
                end
                default: begin
                    w_state_next = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= FILL;
            r_word_count <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_word_count <= w_word_count_next;
            r_in_ready   <= (w_state_next == FILL);
            r_out_valid  <= w_out_valid_next;
        end
    end

`ifdef AES_ASM_SKID_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_out_state <= '0;
        end else if (w_out_load) begin
            r_out_state <= w_out_data;
        end
    end

    assign out_state = r_out_state;
`else
    assign out_state = w_asm_q;
`endif

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign word_count = r_word_count;

endmodule : aes_state_assembler
`default_nettype wire

// File: doc/aes_state_assembler.md
Name: aes_state_assembler

Overview:
- Write-side counterpart to the AES datapath's word/state select muxes.
- Collects four 32-bit column words, arriving serially (e.g. from the per-column InvMixColumns unit), into one 128-bit AES state.
- Presents the assembled state downstream with a valid/ready handshake.
- Sits between the 32-bit column-operation path and the 128-bit round state register in the AES decryption core.

Parameters:
WORD_W, 32, width of one column word
NUM_WORDS, 4, words per state; the state is WORD_W*NUM_WORDS = 128 bits

Ports:
Clk  input  1  system clock, all state updates on the rising edge
Reset_n  input  1  asynchronous, active-low reset
clear  input  1  synchronous abort; discards the partial state and any pending output
in_valid  input  1  in_word is valid this cycle
in_ready  output  1  assembler can accept a word this cycle (registered)
in_word  input  WORD_W  column word; the first word of a state is column 0
out_valid  output  1  out_state holds a complete state (registered)
out_ready  input  1  consumer accepts out_state this cycle
out_state  output  WORD_W*NUM_WORDS  assembled state; column 0 in [127:96], column 3 in [31:0]
word_count  output  2  number of words held in the current partial state

Behaviour:
- Reset (Reset_n low, asynchronous):
  - in_ready=0, out_valid=0, out_state=0, word_count=0, assembly register=0, FSM=FILL.
  - in_ready rises on the first Clk edge after Reset_n deasserts.
- Handshakes:
  - Input transfer = in_valid & in_ready at a Clk edge.
  - Output transfer = out_valid & out_ready at a Clk edge.
  - in_word is ignored when no input transfer occurs.
- FSM FILL:
  - Each input transfer writes in_word into slot word_count (slot k = bits [127-32k -: 32]), then increments word_count.
  - Transfer with word_count=3: word_count wraps to 0, FSM goes to FULL, in_ready=0 and out_valid=1 from the next cycle.
  - Latency: 4th word accepted at edge N -> out_valid=1 after edge N.
- FSM FULL:
  - out_state is stable; in_ready=0.
  - Output transfer: out_valid=0 and in_ready=1 from the next cycle; FSM goes to FILL.
- Back-to-back operation:
  - Without the optional feature, one idle input cycle is required per state: a minimum of 5 cycles per state when out_ready is held high.
- clear:
  - Takes priority over every transfer in the same cycle.
  - Next cycle: word_count=0, out_valid=0, in_ready=1, FSM=FILL.
  - Data registers keep their values (not zeroed). An output transfer coincident with clear is void.
- Data stability:
  - out_state changes only when out_valid=0, or on the cycle following an output transfer.
  - Untouched slots hold stale data while a fill is partial.
- Stall behaviour: out_ready low holds FULL indefinitely; nothing is dropped or overwritten.

Optional Feature:
- Macro: AES_ASM_SKID_EN
- Defined:
  - Adds a separate 128-bit output register; the assembly register becomes internal.
  - On the 4th input transfer, the state moves into the output register if that register is empty or is being drained the same cycle. in_ready stays 1 and filling of the next state starts immediately, giving 4 cycles per state.
  - If the output register is full and not draining, the assembler holds FULL with in_ready=0. The state moves to the output register on the first output transfer, and in_ready=1 the cycle after.
  - clear empties both registers.
- Undefined: the assembly register drives out_state directly, as described in Behaviour.

Decomposition:
- Package aes_asm_pkg holds:
  - localparams AES_WORD_W=32, AES_NUM_WORDS=4, AES_STATE_W=128.
  - enum asm_state_t {FILL, FULL}.
  - A function slot_lsb(idx) returning 96-32*idx.
- One sub-module is natural: aes_state_slot_reg, a 128-bit register with 4 word-enables and a 32-bit write port. Instantiate it once for the assembly register, plus a second plain 128-bit register under AES_ASM_SKID_EN.

Test Plan:
- Reset, then feed 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF with in_valid=1, out_ready=1 -> out_state=128'h00112233_44556677_8899AABB_CCDDEEFF one cycle after the 4th transfer; out_valid pulses for 1 cycle.
- Same stimulus with out_ready=0 for 10 cycles -> out_valid held, out_state stable, in_ready=0 throughout; both drop/rise one cycle after out_ready=1.
- Feed 2 words, assert clear together with the 3rd word's in_valid -> word_count=0, no out_valid; the next 4 words assemble correctly, with no leftover data.
- Assert Reset_n=0 mid-fill (word_count=3) asynchronously -> all outputs 0 immediately; the first Clk edge after release gives in_ready=1.
- Stream 12 words continuously with out_ready=1 -> 3 states in order. Expect 15 cycles without AES_ASM_SKID_EN and 12 cycles with it, with in_ready never dropping.
- With AES_ASM_SKID_EN, hold out_ready=0 while streaming 8 words -> first state held on out_state, second held internally, in_ready=0. Release out_ready -> both states emerge in order on consecutive transfers.
